// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
//   Moore-style main controller for the multicycle MIPS datapath. It sequences
//   fetch / decode / execute / memory / writeback. It also drives the 3-bit
//   operation select consumed by the ALU, using this encoding:
//     000 add, 001 sub, 010 and, 011 or, 100 a+~b, 101 zero, 110 xor, 111 a&~b
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   opcode, funct       instr[31:26] / instr[5:0] from the instruction register
//   zero                ALU result==0 flag, used by beq
//   ir_write            load instruction register
//   pc_en               PC write enable = pc_write | (branch & zero)
//   mem_write           data memory write strobe
//   i_or_d              memory address select (0=PC, 1=ALUOut)
//   reg_write           register-file write enable
//   reg_dst             write register select (0=rt, 1=rd)
//   mem_to_reg          writeback data select (0=ALUOut, 1=MDR)
//   alu_src_a           ALU A select (0=PC, 1=reg A)
//   alu_src_b           ALU B select (00=B, 01=4, 10=imm, 11=imm<<2)
//   imm_zext            zero-extend the immediate (andi/ori)
//   pc_src              next-PC select (00=ALU, 01=ALUOut, 10=jump target)
//   alu_select          ALU operation code
//   illegal_op          pulse for an unsupported opcode/funct
//   state               current state (debug)
module mips_multicycle_control #(
  parameter int STATE_W = 4,
  parameter int SEL_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               ir_write,
  output logic               pc_en,
  output logic               mem_write,
  output logic               i_or_d,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               imm_zext,
  output logic [1:0]         pc_src,
  output logic [SEL_W-1:0]   alu_select,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  localparam logic [STATE_W-1:0] FETCH   = STATE_W'(0);
  localparam logic [STATE_W-1:0] DECODE  = STATE_W'(1);
  localparam logic [STATE_W-1:0] MEMADR  = STATE_W'(2);
  localparam logic [STATE_W-1:0] MEMRD   = STATE_W'(3);
  localparam logic [STATE_W-1:0] MEMWB   = STATE_W'(4);
  localparam logic [STATE_W-1:0] MEMWR   = STATE_W'(5);
  localparam logic [STATE_W-1:0] RTEXEC  = STATE_W'(6);
  localparam logic [STATE_W-1:0] ALUWB   = STATE_W'(7);
  localparam logic [STATE_W-1:0] BRANCH  = STATE_W'(8);
  localparam logic [STATE_W-1:0] IMMEXEC = STATE_W'(9);
  localparam logic [STATE_W-1:0] JUMP    = STATE_W'(10);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [SEL_W-1:0] SEL_ADD  = SEL_W'(3'b000);
  localparam logic [SEL_W-1:0] SEL_SUB  = SEL_W'(3'b001);
  localparam logic [SEL_W-1:0] SEL_AND  = SEL_W'(3'b010);
  localparam logic [SEL_W-1:0] SEL_OR   = SEL_W'(3'b011);
  localparam logic [SEL_W-1:0] SEL_ZERO = SEL_W'(3'b101);
  localparam logic [SEL_W-1:0] SEL_XOR  = SEL_W'(3'b110);

  // R-type funct -> ALU operation; unsupported functs force a zero result.
  function automatic logic [SEL_W-1:0] rtype_sel(input logic [5:0] f);
    case (f)
      6'b100000: rtype_sel = SEL_ADD;
      6'b100010: rtype_sel = SEL_SUB;
      6'b100100: rtype_sel = SEL_AND;
      6'b100101: rtype_sel = SEL_OR;
      6'b100110: rtype_sel = SEL_XOR;
      default:   rtype_sel = SEL_ZERO;
    endcase
  endfunction

  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110: funct_legal = 1'b1;
      default: funct_legal = 1'b0;
    endcase
  endfunction

  function automatic logic opcode_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW: opcode_legal = 1'b1;
      default: opcode_legal = 1'b0;
    endcase
  endfunction

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] next_state;
  logic               pc_write;
  logic               branch;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    pc_write   = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    imm_zext   = 1'b0;
    pc_src     = 2'b00;
    alu_select = SEL_ADD;
    illegal_op = 1'b0;

    case (state_q)
      FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = 2'b01;
        next_state = DECODE;
      end
      DECODE: begin
        // ALU precomputes the branch target into ALUOut while decoding.
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:            next_state = MEMADR;
          OP_RTYPE:                next_state = RTEXEC;
          OP_BEQ:                  next_state = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: next_state = IMMEXEC;
          OP_J:                    next_state = JUMP;
          default:                 next_state = FETCH;
        endcase
        // Bad R-type functs are flagged here as well as in RTEXEC.
        illegal_op = !opcode_legal(opcode) ||
                     ((opcode == OP_RTYPE) && !funct_legal(funct));
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_LW)      next_state = MEMRD;
        else if (opcode == OP_SW) next_state = MEMWR;
        else                      next_state = FETCH;
      end
      MEMRD: begin
        i_or_d     = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      RTEXEC: begin
        alu_src_a  = 1'b1;
        alu_select = rtype_sel(funct);
        illegal_op = !funct_legal(funct);
        next_state = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = (opcode == OP_RTYPE);
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_select = SEL_SUB;
        branch     = 1'b1;
        pc_src     = 2'b01;
      end
      IMMEXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        case (opcode)
          OP_ANDI: alu_select = SEL_AND;
          OP_ORI:  alu_select = SEL_OR;
          default: alu_select = SEL_ADD;
        endcase
        imm_zext   = (opcode == OP_ANDI) || (opcode == OP_ORI);
        next_state = ALUWB;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      default: next_state = FETCH;
    endcase

    pc_en = pc_write | (branch & zero);
    state = state_q;

    // Reset silences every strobe so an abandoned instruction cannot write.
    if (reset) begin
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      imm_zext   = 1'b0;
      pc_src     = 2'b00;
      alu_select = SEL_ADD;
      illegal_op = 1'b0;
      state      = FETCH;
    end
  end

endmodule
